// File: rtl/core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : core_sequencer                                                |
// | Purpose  : Program sequencer for the 9-bit-ISA core. Owns the program    |
// |            counter, the start/run/done handshake, the RUN cycle counter  |
// |            and the sticky PC-wrap error flag, and detects program end    |
// |            (halt address or a run of consecutive all-zero instructions). |
// | Ports    : clk, reset      - clock, synchronous active-high reset       |
// |            start           - launch request (IDLE/DONE only)            |
// |            stall           - hold PC and zero-run counter this cycle    |
// |            mach_code       - instruction currently addressed by pc      |
// |            jump_en/mode/amount - jump request from the control unit     |
// |            pc, running, done, cycle_count, wrap_err - registered status |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module core_sequencer #(
   parameter int                PC_W       = 8,
   parameter int                INSTR_W    = 9,
   parameter int                CNT_W      = 16,
   parameter logic [PC_W-1:0]   START_ADDR = '0,
   parameter logic [PC_W-1:0]   HALT_PC    = '1,
   parameter int                HALT_ZEROS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stall,
   input  logic [INSTR_W-1:0]   mach_code,
   input  logic                 jump_en,
   input  logic [1:0]           jump_mode,
   input  logic [PC_W-1:0]      jump_amount,
   output logic [PC_W-1:0]      pc,
   output logic                 running,
   output logic                 done,
   output logic [CNT_W-1:0]     cycle_count,
   output logic                 wrap_err
);

   // Zero-run counter only needs to reach HALT_ZEROS; halting occurs there.
   localparam int ZW = (HALT_ZEROS < 2) ? 1 : $clog2(HALT_ZEROS + 1);
   localparam logic [ZW-1:0] c_HALT_Z = ZW'(HALT_ZEROS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [PC_W-1:0]     r_pc;
   logic                r_running;
   logic                r_done;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_werr;
   logic [ZW-1:0]       r_zrun;

   logic [PC_W:0]       w_inc;
   logic [PC_W:0]       w_add;
   logic [PC_W:0]       w_sub;
   logic [PC_W-1:0]     w_pc_next;
   logic                w_wrap;
   logic [ZW-1:0]       w_zrun_next;
   logic                w_halt;

   // One extra bit on each path exposes carry (inc/add) or borrow (sub).
   assign w_inc = {1'b0, r_pc} + (PC_W+1)'(1);
   assign w_add = {1'b0, r_pc} + {1'b0, jump_amount};
   assign w_sub = {1'b0, r_pc} - {1'b0, jump_amount};

   assign w_zrun_next = (mach_code == '0) ? (r_zrun + ZW'(1)) : '0;
   assign w_halt      = (r_pc == HALT_PC) || (w_zrun_next == c_HALT_Z);

   always_comb begin
      w_pc_next = w_inc[PC_W-1:0];
      w_wrap    = w_inc[PC_W];
      if (jump_en) begin
         case (jump_mode)
            2'b00: begin
               w_pc_next = w_add[PC_W-1:0];
               w_wrap    = w_add[PC_W];
            end
            2'b01: begin
               w_pc_next = w_sub[PC_W-1:0];
               w_wrap    = w_sub[PC_W];
            end
            2'b10: begin
               w_pc_next = jump_amount;
               w_wrap    = 1'b0;
            end
            default: ;  // reserved mode behaves as a plain increment
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pc      <= START_ADDR;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_cnt     <= '0;
         r_werr    <= 1'b0;
         r_zrun    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state   <= S_RUN;
                  r_pc      <= START_ADDR;
                  r_running <= 1'b1;
                  r_done    <= 1'b0;
                  r_cnt     <= '0;
                  r_werr    <= 1'b0;
                  r_zrun    <= '0;
               end
            end
            S_RUN: begin
               // Stalled cycles still count as RUN cycles.
               if (r_cnt != '1) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               // Stall suppresses both halt and jump; a lost jump must be re-presented.
               if (!stall) begin
                  if (w_halt) begin
                     r_state   <= S_DONE;
                     r_running <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_pc   <= w_pc_next;
                     r_zrun <= w_zrun_next;
                     if (w_wrap) begin
                        r_werr <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign pc          = r_pc;
   assign running     = r_running;
   assign done        = r_done;
   assign cycle_count = r_cnt;
   assign wrap_err    = r_werr;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_core_sequencer                                             |
// | Purpose  : Directed self-checking bench for core_sequencer. Instance     |
// |            dut1 uses default parameters; dut2 uses HALT_ZEROS=3 and a    |
// |            3-bit cycle counter to exercise the zero-run rule and        |
// |            counter saturation.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_core_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stall;
   logic [8:0] mc1;
   logic [8:0] mc2;
   logic       jump_en;
   logic [1:0] jump_mode;
   logic [7:0] jump_amount;

   logic [7:0]  pc1;
   logic        run1;
   logic        done1;
   logic [15:0] cnt1;
   logic        werr1;

   logic [7:0]  pc2;
   logic        run2;
   logic        done2;
   logic [2:0]  cnt2;
   logic        werr2;

   int checks;
   int failures;

   core_sequencer dut1 (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stall       (stall),
      .mach_code   (mc1),
      .jump_en     (jump_en),
      .jump_mode   (jump_mode),
      .jump_amount (jump_amount),
      .pc          (pc1),
      .running     (run1),
      .done        (done1),
      .cycle_count (cnt1),
      .wrap_err    (werr1)
   );

   core_sequencer #(
      .CNT_W      (3),
      .HALT_ZEROS (3)
   ) dut2 (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stall       (stall),
      .mach_code   (mc2),
      .jump_en     (jump_en),
      .jump_mode   (jump_mode),
      .jump_amount (jump_amount),
      .pc          (pc2),
      .running     (run2),
      .done        (done2),
      .cycle_count (cnt2),
      .wrap_err    (werr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (pc1 !== 8'h00) begin failures++; $display("FAIL reset_pc: got %0h expected 0", pc1); end
      checks++; if (run1 !== 1'b0) begin failures++; $display("FAIL reset_running: got %0b expected 0", run1); end
      checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done1); end
      checks++; if (cnt1 !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", cnt1); end
      checks++; if (werr1 !== 1'b0) begin failures++; $display("FAIL reset_wrap: got %0b expected 0", werr1); end
      reset = 1'b0;
      tick();
      checks++; if (run1 !== 1'b0) begin failures++; $display("FAIL idle_hold: running got %0b expected 0", run1); end
   endtask

   task automatic test_run_halt();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (run1 !== 1'b1 || pc1 !== 8'h00) begin failures++; $display("FAIL launch: running=%0b pc=%0h expected 1/0", run1, pc1); end
      for (int i = 1; i <= 5; i++) begin
         mc1 = 9'h1A + 9'(i);
         tick();
         checks++; if (pc1 !== 8'(i)) begin failures++; $display("FAIL seq_pc%0d: got %0h expected %0h", i, pc1, i); end
      end
      mc1 = 9'h000;
      tick();
      checks++; if (done1 !== 1'b1 || run1 !== 1'b0) begin failures++; $display("FAIL zero_halt: done=%0b running=%0b expected 1/0", done1, run1); end
      checks++; if (pc1 !== 8'h05) begin failures++; $display("FAIL halt_pc: got %0h expected 5", pc1); end
      checks++; if (cnt1 !== 16'd6) begin failures++; $display("FAIL halt_count: got %0d expected 6", cnt1); end
      tick();
      checks++; if (cnt1 !== 16'd6 || pc1 !== 8'h05 || done1 !== 1'b1) begin failures++; $display("FAIL done_frozen: cnt=%0d pc=%0h done=%0b expected 6/5/1", cnt1, pc1, done1); end
      mc1 = 9'h001;
   endtask

   task automatic test_jumps();
      logic [1:0] modes [7] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
      logic [7:0] amts  [7] = '{8'd3, 8'd4, 8'd2, 8'd4, 8'h20, 8'd4, 8'd9};
      logic [7:0] exps  [7] = '{8'd7, 8'd4, 8'd2, 8'd4, 8'h20, 8'd4, 8'd5};
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (pc1 !== 8'h00 || done1 !== 1'b0 || cnt1 !== 16'd0 || run1 !== 1'b1) begin failures++; $display("FAIL relaunch: pc=%0h done=%0b cnt=%0d run=%0b expected 0/0/0/1", pc1, done1, cnt1, run1); end
      repeat (4) tick();
      checks++; if (pc1 !== 8'h04) begin failures++; $display("FAIL pre_jump_pc: got %0h expected 4", pc1); end
      jump_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         jump_mode   = modes[i];
         jump_amount = amts[i];
         tick();
         checks++; if (pc1 !== exps[i] || werr1 !== 1'b0) begin failures++; $display("FAIL jump%0d: pc=%0h wrap=%0b expected %0h/0", i, pc1, werr1, exps[i]); end
      end
      jump_en = 1'b0;
   endtask

   task automatic test_wrap();
      logic [1:0] modes [4] = '{2'd2, 2'd0, 2'd2, 2'd1};
      logic [7:0] amts  [4] = '{8'hFE, 8'd4, 8'd1, 8'd3};
      logic [7:0] exps  [4] = '{8'hFE, 8'h02, 8'h01, 8'hFE};
      logic       werrs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      jump_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         jump_mode   = modes[i];
         jump_amount = amts[i];
         tick();
         checks++; if (pc1 !== exps[i] || werr1 !== werrs[i]) begin failures++; $display("FAIL wrap%0d: pc=%0h wrap=%0b expected %0h/%0b", i, pc1, werr1, exps[i], werrs[i]); end
      end
      jump_en = 1'b0;
      mc1 = 9'h000;
      tick();
      checks++; if (done1 !== 1'b1 || werr1 !== 1'b1 || pc1 !== 8'hFE) begin failures++; $display("FAIL wrap_done: done=%0b wrap=%0b pc=%0h expected 1/1/fe", done1, werr1, pc1); end
      mc1 = 9'h001;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (werr1 !== 1'b0 || pc1 !== 8'h00 || done1 !== 1'b0) begin failures++; $display("FAIL wrap_clear: wrap=%0b pc=%0h done=%0b expected 0/0/0", werr1, pc1, done1); end
   endtask

   task automatic test_stall();
      repeat (2) tick();
      checks++; if (pc1 !== 8'h02 || cnt1 !== 16'd2) begin failures++; $display("FAIL pre_stall: pc=%0h cnt=%0d expected 2/2", pc1, cnt1); end
      stall       = 1'b1;
      jump_en     = 1'b1;
      jump_mode   = 2'd2;
      jump_amount = 8'h40;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (pc1 !== 8'h02 || cnt1 !== 16'(2 + k)) begin failures++; $display("FAIL stall%0d: pc=%0h cnt=%0d expected 2/%0d", k, pc1, cnt1, 2 + k); end
      end
      stall   = 1'b0;
      jump_en = 1'b0;
      tick();
      checks++; if (pc1 !== 8'h03 || cnt1 !== 16'd7) begin failures++; $display("FAIL post_stall: pc=%0h cnt=%0d expected 3/7", pc1, cnt1); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (pc1 !== 8'h00 || run1 !== 1'b0 || done1 !== 1'b0 || cnt1 !== 16'd0) begin failures++; $display("FAIL mid_reset: pc=%0h run=%0b done=%0b cnt=%0d expected 0/0/0/0", pc1, run1, done1, cnt1); end
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      checks++; if (run1 !== 1'b0) begin failures++; $display("FAIL reset_beats_start: running got %0b expected 0", run1); end
   endtask

   task automatic test_halt_pc();
      start = 1'b1;
      tick();
      jump_en     = 1'b1;
      jump_mode   = 2'd2;
      jump_amount = 8'hFF;
      tick();
      checks++; if (pc1 !== 8'hFF || run1 !== 1'b1 || done1 !== 1'b0) begin failures++; $display("FAIL start_in_run: pc=%0h run=%0b done=%0b expected ff/1/0", pc1, run1, done1); end
      start       = 1'b0;
      jump_amount = 8'h10;
      tick();
      checks++; if (done1 !== 1'b1 || run1 !== 1'b0 || pc1 !== 8'hFF || cnt1 !== 16'd2) begin failures++; $display("FAIL halt_pc_done: done=%0b run=%0b pc=%0h cnt=%0d expected 1/0/ff/2", done1, run1, pc1, cnt1); end
      jump_en = 1'b0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      checks++; if (pc1 !== 8'h00 || run1 !== 1'b1 || done1 !== 1'b0 || cnt1 !== 16'd0) begin failures++; $display("FAIL relaunch_done: pc=%0h run=%0b done=%0b cnt=%0d expected 0/1/0/0", pc1, run1, done1, cnt1); end
   endtask

   task automatic test_zero_run();
      logic       stl  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [8:0] code [8] = '{9'd1, 9'd0, 9'd0, 9'd5, 9'd0, 9'd0, 9'd0, 9'd0};
      logic [7:0] epc  [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd6, 8'd6};
      logic       edn  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0] ecnt [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (pc2 !== 8'h00 || run2 !== 1'b1) begin failures++; $display("FAIL z_launch: pc=%0h run=%0b expected 0/1", pc2, run2); end
      for (int i = 0; i < 8; i++) begin
         stall = stl[i];
         mc2   = code[i];
         tick();
         checks++; if (pc2 !== epc[i] || done2 !== edn[i] || cnt2 !== ecnt[i]) begin failures++; $display("FAIL zrun%0d: pc=%0h done=%0b cnt=%0d expected %0h/%0b/%0d", i, pc2, done2, cnt2, epc[i], edn[i], ecnt[i]); end
      end
      stall = 1'b0;
      mc2   = 9'h001;
      checks++; if (run2 !== 1'b0) begin failures++; $display("FAIL zrun_running: got %0b expected 0", run2); end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      start       = 1'b0;
      stall       = 1'b0;
      mc1         = 9'h001;
      mc2         = 9'h001;
      jump_en     = 1'b0;
      jump_mode   = 2'd0;
      jump_amount = 8'h00;
      test_reset();
      test_run_halt();
      test_jumps();
      test_wrap();
      test_stall();
      test_halt_pc();
      test_zero_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Parametrised program-sequencing block for the 9-bit-ISA core: it owns the program counter and the start/run/done handshake, and detects program end. It generalises the fixed 8-bit PC with a single jump input and a one-shot halt check. It adds configurable PC/instruction widths, three jump modes, stall support, a consecutive-zero-instruction halt rule, a cycle counter and a sticky wrap-error flag. It sits between the control unit (jump requests) and the combinational instruction memory (consumes `pc`, returns `mach_code`).

## Interface
- PC_W, 8, program counter width
- INSTR_W, 9, instruction width
- CNT_W, 16, cycle counter width
- START_ADDR, 0, PC value loaded on reset and on start
- HALT_PC, 2**PC_W-1, PC value whose execution ends the program
- HALT_ZEROS, 1, number of consecutive all-zero instructions that ends the program (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch request; sampled in IDLE and DONE only
- stall  in  1  hold PC this cycle
- mach_code  in  INSTR_W  instruction currently at `pc`
- jump_en  in  1  take jump this cycle
- jump_mode  in  2  00 pc+amount, 01 pc−amount, 10 absolute amount, 11 reserved (treated as no jump)
- jump_amount  in  PC_W  jump offset/target
- pc  out  PC_W  current program counter
- running  out  1  high in RUN
- done  out  1  high in DONE
- cycle_count  out  CNT_W  RUN cycles since launch, saturating
- wrap_err  out  1  sticky: PC arithmetic wrapped modulo 2**PC_W

## Operation
- States: IDLE, RUN, DONE. All outputs registered.
- Reset (any state, mid-run included): IDLE, pc=START_ADDR, done=0, running=0, cycle_count=0, wrap_err=0, zero-run counter=0.
- IDLE: start=1 → RUN next cycle. pc=START_ADDR, counters cleared.
- RUN, per cycle:
  - cycle_count += 1 (stalled cycles included), saturating at 2**CNT_W−1.
  - stall=1: pc, zero-run counter hold. Jump and halt are not evaluated.
  - otherwise, halt check first:
    - The zero-run count is zrun' = (mach_code==0) ? zrun+1 : 0.
    - If pc==HALT_PC or zrun'==HALT_ZEROS, go to DONE. pc holds. Any jump is ignored.
  - otherwise next pc:
    - mode 00: pc+amount
    - mode 01: pc−amount
    - mode 10: amount
    - jump_en=0 or mode 11: pc+1
    - All modulo 2**PC_W.
  - wrap_err is set on a carry out of pc+1 or pc+amount, or on a borrow from pc−amount. Absolute jumps never set it.
  - start in RUN is ignored.
- DONE: done=1, pc and cycle_count frozen. start=1 → RUN, with pc=START_ADDR, cycle_count=0, zero-run counter=0, wrap_err=0, done=0.
- HALT_ZEROS=1: a single zero instruction halts. Zero instructions below threshold execute as normal (pc+1 or jump).

## Timing
- start sampled at edge N → running=1, pc=START_ADDR visible after edge N; first instruction executes in cycle N+1.
- Jump/increment: pc updates at the edge ending the cycle in which jump_en/mach_code are valid; one-cycle latency, no bubbles.
- Halt: condition true in cycle K → done=1, running=0 after edge K. pc still shows the halting address.
- done stays high until reset or start. start while done=1 → done=0 after that edge.
- start and reset in same cycle: reset wins.
- stall and jump_en in same cycle: stall wins, jump is lost (the control unit must re-present it).
- cycle_count counts cycles with running=1 before the edge: K−N cycles for launch at N and halt at K.

## Test plan
- Reset, start at cycle 2, 5 non-zero instructions then a zero (HALT_ZEROS=1) → pc 0,1,2,3,4,5, done=1 after the 6th RUN edge, pc=5, cycle_count=6.
- Jumps at pc=4: mode 00 amt 3 → 7; mode 01 amt 2 → 2; mode 10 amt 0x20 → 0x20; mode 11 → 5. wrap_err stays 0.
- pc=0xFE, mode 00 amt 4 → pc=0x02, wrap_err=1. Then from pc=0x01, mode 01 amt 3 → 0xFE; wrap_err stays 1. After start from DONE, wrap_err=0.
- HALT_ZEROS=3, instruction stream nz,0,0,nz,0,0,0 → no halt at the first pair; done after the third consecutive zero. A stall inserted between zeros does not reset the run.
- Stall held 4 cycles with jump_en=1 → pc unchanged, cycle_count +4. Reset asserted mid-RUN → next cycle IDLE, pc=0, done=0, cycle_count=0.
- pc reaches HALT_PC=0xFF with jump_en=1 → DONE, pc=0xFF; start in RUN ignored. start in DONE relaunches at pc=START_ADDR.
